// File: rtl/updi_pkg.sv
// Shared types and helpers for the UPDI link arbiter: FSM state encoding and
// the round-robin requester picker.
package updi_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_DRAIN,
    ARB_GUARD,
    ARB_FLUSH
  } updi_arb_state;

  localparam int unsigned RR_MAX = 8;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } rr_pick_t;

  // First requester strictly after `last`, wrapping modulo n (n <= RR_MAX).
  // Walks the distance downward so the nearest hit is the last one written.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] req,
                                       input logic [2:0]        last,
                                       input int unsigned       n);
    rr_pick_t    r;
    int unsigned k;
    r = '0;
    for (int unsigned i = RR_MAX; i >= 1; i--) begin
      if (i <= n) begin
        k = (32'(last) + i) % n;
        if (req[k[2:0]]) begin
          r.valid = 1'b1;
          r.idx   = k[2:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/delay.sv
// Enable-held cycle timer: done_o rises on the N_CLKS-th consecutive enabled
// cycle; dropping en_i clears the count.
module delay #(
  parameter int unsigned N_CLKS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic done_o
);
  localparam int unsigned CW = $clog2(N_CLKS + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign done_o = en_i && (cnt_q == CW'(N_CLKS - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || done_o) cnt_d = '0;
    else                 cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/updi_link_arbiter.sv
// Transaction-level round-robin lock over one UART PHY shared by N UPDI masters;
// each hand-over drains TX, waits the echo guard time and flushes stale RX.
module updi_link_arbiter
  import updi_pkg::*;
#(
  parameter int unsigned N_CLIENTS        = 2,
  parameter int unsigned MAX_HOLD_CLKS    = 65535,
  parameter int unsigned DRAIN_GUARD_CLKS = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CLIENTS-1:0]      req,
  output logic [N_CLIENTS-1:0]      gnt,
  input  logic [N_CLIENTS-1:0][7:0] c_tx_data,
  input  logic [N_CLIENTS-1:0]      c_tx_wr_en,
  output logic [N_CLIENTS-1:0]      c_tx_full,
  output logic [7:0]                c_rx_data,
  input  logic [N_CLIENTS-1:0]      c_rx_rd_en,
  output logic [N_CLIENTS-1:0]      c_rx_empty,
  input  logic [N_CLIENTS-1:0]      c_db_start,
  output logic [N_CLIENTS-1:0]      c_db_busy,
  output logic [N_CLIENTS-1:0]      c_db_done,
  output logic [7:0]                uart_tx_fifo_data_in,
  output logic                      uart_tx_fifo_wr_en,
  input  logic                      uart_tx_fifo_full,
  input  logic                      uart_tx_fifo_empty,
  input  logic                      uart_tx_busy,
  input  logic [7:0]                uart_rx_fifo_data_out,
  output logic                      uart_rx_fifo_rd_en,
  input  logic                      uart_rx_fifo_empty,
  output logic                      double_break_start,
  input  logic                      double_break_busy,
  input  logic                      double_break_done,
  output logic [N_CLIENTS-1:0]      hold_timeout,
  output logic                      flushing
);

  updi_arb_state          state_q, state_d;
  logic [2:0]             owner_q, owner_d, last_q, last_d;
  logic [31:0]            hold_cnt_q, hold_cnt_d;
  logic [N_CLIENTS-1:0]   gnt_q, gnt_d, hto_q, hto_d;
  logic [RR_MAX-1:0]      req_pad;
  rr_pick_t               pick;
  logic                   guard_en, guard_done, drain_ok, own;

  always_comb begin
    req_pad                = '0;
    req_pad[N_CLIENTS-1:0] = req;
  end

  assign pick     = rr_pick(req_pad, last_q, N_CLIENTS);
  assign drain_ok = uart_tx_fifo_empty && !uart_tx_busy && !double_break_busy;
  assign guard_en = (state_q == ARB_GUARD);

  delay #(.N_CLKS(DRAIN_GUARD_CLKS)) u_guard (
    .clk    (clk),
    .rst    (rst),
    .en_i   (guard_en),
    .done_o (guard_done)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    hto_d      = '0;
    case (state_q)
      ARB_IDLE: if (pick.valid) begin
        state_d    = ARB_GRANT;
        owner_d    = pick.idx;
        last_d     = pick.idx;
        hold_cnt_d = '0;
        for (int g = 0; g < N_CLIENTS; g++) gnt_d[g] = (pick.idx == 3'(g));
      end
      ARB_GRANT: begin
        if (!req_pad[owner_q]) begin
          state_d = ARB_DRAIN;
          gnt_d   = '0;
        end else if (MAX_HOLD_CLKS != 0 && hold_cnt_q == 32'(MAX_HOLD_CLKS - 1)) begin
          state_d = ARB_DRAIN;
          gnt_d   = '0;
          for (int g = 0; g < N_CLIENTS; g++) hto_d[g] = (owner_q == 3'(g));
        end else if (hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      ARB_DRAIN: if (drain_ok)            state_d = ARB_GUARD;
      ARB_GUARD: if (guard_done)          state_d = ARB_FLUSH;
      ARB_FLUSH: if (uart_rx_fifo_empty)  state_d = ARB_IDLE;
      default:                            state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      owner_q    <= '0;
      last_q     <= 3'(N_CLIENTS - 1);
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      hto_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      hto_q      <= hto_d;
    end
  end

  // PHY side: only the owner reaches the PHY, and reset silences it at once.
  assign own = (state_q == ARB_GRANT) && !rst;

  always_comb begin
    uart_tx_fifo_data_in = '0;
    uart_tx_fifo_wr_en   = 1'b0;
    double_break_start   = 1'b0;
    uart_rx_fifo_rd_en   = (state_q == ARB_FLUSH) && !rst && !uart_rx_fifo_empty;
    for (int g = 0; g < N_CLIENTS; g++) begin
      if (own && owner_q == 3'(g)) begin
        uart_tx_fifo_data_in = c_tx_data[g];
        uart_tx_fifo_wr_en   = c_tx_wr_en[g];
        double_break_start   = c_db_start[g];
        uart_rx_fifo_rd_en   = c_rx_rd_en[g];
      end
    end
  end

  for (genvar g = 0; g < N_CLIENTS; g++) begin : g_client
    logic is_own;
    assign is_own        = own && (owner_q == 3'(g));
    assign c_tx_full[g]  = is_own ? uart_tx_fifo_full  : 1'b1;
    assign c_rx_empty[g] = is_own ? uart_rx_fifo_empty : 1'b1;
    assign c_db_busy[g]  = is_own ? double_break_busy  : 1'b1;
    assign c_db_done[g]  = is_own ? double_break_done  : 1'b0;
  end

  assign c_rx_data    = uart_rx_fifo_data_out;
  assign gnt          = gnt_q;
  assign hold_timeout = hto_q;
  assign flushing     = !rst && (state_q == ARB_DRAIN || state_q == ARB_GUARD ||
                                 state_q == ARB_FLUSH);

endmodule
